// File: rtl/div5b_pkg.sv
// Shared constants and state encoding for the 5-bit restoring divider (div5bs).
package div5b_pkg;

    localparam int W    = 5;
    localparam int ITER = 5;
    localparam int CW   = 3;

    localparam logic [CW-1:0] CNT_INIT = CW'(ITER - 1);
    localparam logic [W-1:0]  QMAX     = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/res6bj.sv
// res6bj: 6-bit ripple subtractor built from adder cells on the inverted subtrahend.
// Carry-in is 1 (two's complement); o_borrow is the inverted final carry.
module res6bj
    import div5b_pkg::*;
(
    input  logic [W:0] i_a,
    input  logic [W:0] i_b,
    output logic [W:0] o_d,
    output logic       o_borrow
);

    logic [W+1:0] w_carry;

    assign w_carry[0] = 1'b1;

    for (genvar i = 0; i <= W; i++) begin : g_cell
        logic w_bInv;
        assign w_bInv       = ~i_b[i];
        assign o_d[i]       = i_a[i] ^ w_bInv ^ w_carry[i];
        assign w_carry[i+1] = (i_a[i] & w_bInv) | (w_carry[i] & (i_a[i] ^ w_bInv));
    end

    assign o_borrow = ~w_carry[W+1];

endmodule

// File: rtl/div5bs.sv
// div5bs: 5-bit sequential restoring divider, one quotient bit per clock, MSB first.
// Define DIV5BS_DIVZERO_EN for a one-cycle divide-by-zero shortcut that raises err.
module div5bs
    import div5b_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] q,
    output logic [W-1:0] r,
    output logic         err
);

    state_t        r_state;
    logic [W-1:0]  r_dividend;
    logic [W-1:0]  r_divisor;
    logic [W-1:0]  r_rem;
    logic [W-1:0]  r_quot;
    logic [CW-1:0] r_count;
`ifdef DIV5BS_DIVZERO_EN
    logic          r_divZero;
`endif

    logic [W:0]    w_p;
    logic [W:0]    w_d;
    logic          w_borrow;
    logic          w_unusedDiffMsb;
    logic [W-1:0]  w_nextRem;
    logic [W-1:0]  w_nextQuot;

    assign w_p = {r_rem, r_dividend[W-1]};

    res6bj u_sub (
        .i_a      (w_p),
        .i_b      ({1'b0, r_divisor}),
        .o_d      (w_d),
        .o_borrow (w_borrow)
    );

    // A borrow means the trial subtraction failed: keep the shifted partial remainder.
    assign w_nextRem       = w_borrow ? w_p[W-1:0] : w_d[W-1:0];
    assign w_nextQuot      = {r_quot[W-2:0], ~w_borrow};
    assign w_unusedDiffMsb = w_d[W];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_dividend <= '0;
            r_divisor  <= '0;
            r_rem      <= '0;
            r_quot     <= '0;
            r_count    <= '0;
`ifdef DIV5BS_DIVZERO_EN
            r_divZero  <= 1'b0;
`endif
            busy       <= 1'b0;
            done       <= 1'b0;
            q          <= '0;
            r          <= '0;
            err        <= 1'b0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        r_dividend <= a;
                        r_divisor  <= b;
                        r_rem      <= '0;
                        r_quot     <= '0;
                        r_count    <= CNT_INIT;
`ifdef DIV5BS_DIVZERO_EN
                        r_divZero  <= (b == '0);
`endif
                        busy       <= 1'b1;
                        r_state    <= RUN;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                RUN: begin
`ifdef DIV5BS_DIVZERO_EN
                    // Dividend is still unshifted here, so it is the remainder as captured.
                    if (r_divZero) begin
                        q       <= QMAX;
                        r       <= r_dividend;
                        err     <= 1'b1;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        r_state <= DONE;
                    end else
`endif
                    begin
                        r_rem      <= w_nextRem;
                        r_quot     <= w_nextQuot;
                        r_dividend <= {r_dividend[W-2:0], 1'b0};
                        r_count    <= r_count - CW'(1);
                        if (r_count == '0) begin
                            q       <= w_nextQuot;
                            r       <= w_nextRem;
                            err     <= 1'b0;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            r_state <= DONE;
                        end
                    end
                end
                default: begin
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
